// File: rtl/seg7_scan_mux_if.sv
// Bus between the counter/prescaler stage and the 4-digit scan multiplexer.
// The master drives value/strobe/enable; the slave (scan mux) drives the display pins.
interface seg7_scan_mux_if;
    logic        CE;
    logic [15:0] DATA;
    logic [3:0]  DP;
    logic        LOAD;
    logic [7:0]  SEG;
    logic [3:0]  DIG;
    logic        FRAME;
    logic        LOAD_PEND;

    modport master (
        output CE, DATA, DP, LOAD,
        input  SEG, DIG, FRAME, LOAD_PEND
    );

    modport slave (
        input  CE, DATA, DP, LOAD,
        output SEG, DIG, FRAME, LOAD_PEND
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// 4-digit 7-seg scan multiplexer with per-slot blanking and frame-synchronous double buffer.
// Optional: define LEADING_ZERO_BLANK_EN to suppress segments of leading zero digits.
module seg7_scan_mux #(
    parameter int unsigned DIV   = 256,
    parameter int unsigned BLANK = 16
) (
    input  logic            C,
    input  logic            CLR,
    seg7_scan_mux_if.slave  bus
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [19:0]   pbuf_q, pbuf_d;
    logic [19:0]   dbuf_q, dbuf_d;
    logic          pend_q, pend_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    dig_q, dig_d;
    logic          frame_q, frame_d;

    logic          slot_end;
    logic          boundary;
    logic [3:0]    nib;
    logic          dp_bit;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            pbuf_q  <= '0;
            dbuf_q  <= '0;
            pend_q  <= 1'b0;
            seg_q   <= '0;
            dig_q   <= '0;
            frame_q <= 1'b0;
        end else if (bus.CE) begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pbuf_q  <= pbuf_d;
            dbuf_q  <= dbuf_d;
            pend_q  <= pend_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        slot_end = (cnt_q == CW'(DIV - 1));
        boundary = slot_end && (idx_q == 2'd3);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
        frame_d  = boundary;
    end

    // A LOAD landing on the boundary edge bypasses pbuf so it is not deferred a whole frame.
    always_comb begin
        pbuf_d = bus.LOAD ? {bus.DP, bus.DATA} : pbuf_q;
        dbuf_d = dbuf_q;
        pend_d = pend_q;
        if (boundary) begin
            pend_d = 1'b0;
            if (bus.LOAD)
                dbuf_d = {bus.DP, bus.DATA};
            else if (pend_q)
                dbuf_d = pbuf_q;
        end else if (bus.LOAD) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    nib = dbuf_q[3:0];
            2'd1:    nib = dbuf_q[7:4];
            2'd2:    nib = dbuf_q[11:8];
            default: nib = dbuf_q[15:12];
        endcase
        dp_bit = dbuf_q[16 + {30'd0, idx_q}];
    end

`ifdef LEADING_ZERO_BLANK_EN
    // lead_zero[k]: nibbles k..3 are all zero; digit 0 is never treated as leading.
    logic [3:0] lead_zero;
    always_comb begin
        lead_zero[3] = (dbuf_q[15:12] == 4'h0);
        lead_zero[2] = lead_zero[3] && (dbuf_q[11:8] == 4'h0);
        lead_zero[1] = lead_zero[2] && (dbuf_q[7:4] == 4'h0);
        lead_zero[0] = 1'b0;
    end
`endif

    always_comb begin
        seg_d = '0;
        dig_d = '0;
        if (cnt_q >= CW'(BLANK)) begin
            dig_d = 4'b0001 << idx_q;
`ifdef LEADING_ZERO_BLANK_EN
            seg_d = lead_zero[idx_q] ? {dp_bit, 7'h00} : {dp_bit, hex7(nib)};
`else
            seg_d = {dp_bit, hex7(nib)};
`endif
        end
    end

    assign bus.SEG       = seg_q;
    assign bus.DIG       = dig_q;
    assign bus.FRAME     = frame_q;
    assign bus.LOAD_PEND = pend_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux (DIV=8, BLANK=2) against a position-arithmetic display model.
module tb_seg7_scan_mux;
    localparam int unsigned DIV   = 8;
    localparam int unsigned BLANK = 2;
    localparam int unsigned FRM   = 4 * DIV;

    logic C   = 1'b0;
    logic CLR = 1'b0;

    seg7_scan_mux_if bus ();

    seg7_scan_mux #(.DIV(DIV), .BLANK(BLANK)) dut (
        .C   (C),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 C = ~C;

    logic [6:0] HEX [16];
    initial begin
        HEX[0]  = 7'h3F; HEX[1]  = 7'h06; HEX[2]  = 7'h5B; HEX[3]  = 7'h4F;
        HEX[4]  = 7'h66; HEX[5]  = 7'h6D; HEX[6]  = 7'h7D; HEX[7]  = 7'h07;
        HEX[8]  = 7'h7F; HEX[9]  = 7'h6F; HEX[10] = 7'h77; HEX[11] = 7'h7C;
        HEX[12] = 7'h39; HEX[13] = 7'h5E; HEX[14] = 7'h79; HEX[15] = 7'h71;
    end

    // Model: n = enabled edges since reset; scan position follows from n by arithmetic.
    int unsigned n;
    logic [19:0] m_dbuf, m_pbuf;
    logic        m_pend;
    logic [7:0]  e_seg;
    logic [3:0]  e_dig;
    logic        e_frame;

    function automatic logic [7:0] exp_seg(input int unsigned p, input logic [19:0] db);
        int unsigned d;
        int unsigned h;
        logic [3:0]  v;
        d = (p / DIV) % 4;
        h = 0;
        if ((p % DIV) < BLANK) return 8'h00;
        for (int unsigned i = 0; i < 4; i++)
            if (db[4*i +: 4] != 4'h0) h = i;
        v = db[4*d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (d > h) return {db[16+d], 7'h00};
`endif
        return {db[16+d], HEX[v]};
    endfunction

    function automatic logic [3:0] exp_dig(input int unsigned p);
        if ((p % DIV) < BLANK) return 4'h0;
        return 4'(1 << ((p / DIV) % 4));
    endfunction

    always @(posedge C or posedge CLR) begin
        if (CLR) begin
            n       <= 0;
            m_dbuf  <= '0;
            m_pbuf  <= '0;
            m_pend  <= 1'b0;
            e_seg   <= '0;
            e_dig   <= '0;
            e_frame <= 1'b0;
        end else if (bus.CE) begin
            e_seg   <= exp_seg(n, m_dbuf);
            e_dig   <= exp_dig(n);
            e_frame <= ((n % FRM) == FRM - 1);
            if ((n % FRM) == FRM - 1) begin
                if (bus.LOAD) m_dbuf <= {bus.DP, bus.DATA};
                else if (m_pend) m_dbuf <= m_pbuf;
                m_pend <= 1'b0;
            end else if (bus.LOAD) begin
                m_pend <= 1'b1;
            end
            if (bus.LOAD) m_pbuf <= {bus.DP, bus.DATA};
            n <= n + 1;
        end
    end

    int nchk  = 0;
    int nfail = 0;
    int fcount;
    logic watch06;
    logic seen06;

    task automatic check_model();
        nchk++;
        if ({bus.SEG, bus.DIG, bus.FRAME, bus.LOAD_PEND} !== {e_seg, e_dig, e_frame, m_pend}) begin
            nfail++;
            $display("FAIL model t=%0t pos=%0d: SEG=%h DIG=%h FRAME=%b PEND=%b, required SEG=%h DIG=%h FRAME=%b PEND=%b",
                     $time, n, bus.SEG, bus.DIG, bus.FRAME, bus.LOAD_PEND, e_seg, e_dig, e_frame, m_pend);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s t=%0t: got %h, required %h", name, $time, act, req);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
        check_model();
        if (bus.FRAME === 1'b1) fcount++;
        if (watch06 && bus.SEG === 8'h06) seen06 = 1'b1;
    endtask

    task automatic run(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) tick();
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p);
        bus.LOAD = 1'b1;
        bus.DATA = d;
        bus.DP   = p;
        tick();
        bus.LOAD = 1'b0;
        bus.DATA = ~d;
        bus.DP   = ~p;
    endtask

    initial begin
        bus.CE   = 1'b1;
        bus.LOAD = 1'b0;
        bus.DATA = 16'hBEEF;
        bus.DP   = 4'hF;
        fcount   = 0;
        watch06  = 1'b0;
        seen06   = 1'b0;

        // Reset and free-running scan of "0000"
        #2 CLR = 1'b1;
        #1;
        lit("rst_seg", 32'(bus.SEG), 32'h00);
        lit("rst_dig", 32'(bus.DIG), 32'h0);
        check_model();
        tick();
        tick();
        CLR = 1'b0;
        fcount = 0;
        run(3);
        lit("scan_first_dig", 32'(bus.DIG), 32'h1);
        lit("scan_first_seg", 32'(bus.SEG), 32'h3F);
        run(61);
        lit("frame_count", 32'(fcount), 32'd2);

        // Deferred load at cycle 5 of the frame
        run(5);
        load(16'h12AF, 4'b0100);
        lit("pend_set", 32'(bus.LOAD_PEND), 32'h1);
        run(25);
        lit("pend_hold", 32'(bus.LOAD_PEND), 32'h1);
        lit("old_frame_seg", 32'(bus.SEG), 32'h3F);
        tick();
        lit("boundary_frame", 32'(bus.FRAME), 32'h1);
        lit("boundary_pend", 32'(bus.LOAD_PEND), 32'h0);
        run(3);
        lit("new_d0", 32'(bus.SEG), 32'h71);
        run(8);
        lit("new_d1", 32'(bus.SEG), 32'h77);
        run(8);
        lit("new_d2_dp", 32'(bus.SEG), 32'hDB);
        run(8);
        lit("new_d3", 32'(bus.SEG), 32'h06);
        lit("new_d3_dig", 32'(bus.DIG), 32'h8);
        run(5);

        // Load on the boundary edge wins over an earlier pending load
        run(10);
        load(16'h1111, 4'b0000);
        run(20);
        load(16'h2222, 4'b0000);
        lit("collide_pend", 32'(bus.LOAD_PEND), 32'h0);
        watch06 = 1'b1;
        run(3);
        lit("collide_d0", 32'(bus.SEG), 32'h5B);
        run(29);
        watch06 = 1'b0;
        lit("collide_no06", 32'(seen06), 32'h0);

        // CE freeze mid digit-2 slot, then exact remaining slot length
        run(20);
        bus.CE = 1'b0;
        run(20);
        lit("freeze_dig", 32'(bus.DIG), 32'h4);
        lit("freeze_seg", 32'(bus.SEG), 32'h5B);
        bus.CE = 1'b1;
        run(4);
        lit("resume_tail", 32'(bus.DIG), 32'h4);
        run(1);
        lit("resume_blank", 32'(bus.DIG), 32'h0);
        run(7);
        lit("frame_pulse", 32'(bus.FRAME), 32'h1);
        bus.CE = 1'b0;
        run(3);
        lit("frame_frozen", 32'(bus.FRAME), 32'h1);
        bus.CE = 1'b1;
        tick();
        lit("frame_drop", 32'(bus.FRAME), 32'h0);

        // Reset while digit 3 is shown with a load pending
        run(23);
        load(16'h9876, 4'b0001);
        run(2);
        lit("pre_clr_dig", 32'(bus.DIG), 32'h8);
        lit("pre_clr_pend", 32'(bus.LOAD_PEND), 32'h1);
        CLR = 1'b1;
        #1;
        lit("clr_seg", 32'(bus.SEG), 32'h00);
        lit("clr_dig", 32'(bus.DIG), 32'h0);
        lit("clr_pend", 32'(bus.LOAD_PEND), 32'h0);
        check_model();
        tick();
        CLR = 1'b0;
        run(3);
        lit("restart_dig", 32'(bus.DIG), 32'h1);
        lit("restart_seg", 32'(bus.SEG), 32'h3F);

        // 0042 then 0000: leading-zero behaviour depends on build option
        run(28);
        load(16'h0042, 4'b0000);
        run(3);
        lit("v42_d0", 32'(bus.SEG), 32'h5B);
        run(8);
        lit("v42_d1", 32'(bus.SEG), 32'h66);
        run(8);
        lit("v42_d2_dig", 32'(bus.DIG), 32'h4);
`ifdef LEADING_ZERO_BLANK_EN
        lit("v42_d2", 32'(bus.SEG), 32'h00);
`else
        lit("v42_d2", 32'(bus.SEG), 32'h3F);
`endif
        run(8);
        lit("v42_d3_dig", 32'(bus.DIG), 32'h8);
`ifdef LEADING_ZERO_BLANK_EN
        lit("v42_d3", 32'(bus.SEG), 32'h00);
`else
        lit("v42_d3", 32'(bus.SEG), 32'h3F);
`endif
        run(4);
        load(16'h0000, 4'b0000);
        run(3);
        lit("v0_d0", 32'(bus.SEG), 32'h3F);
        run(8);
`ifdef LEADING_ZERO_BLANK_EN
        lit("v0_d1", 32'(bus.SEG), 32'h00);
`else
        lit("v0_d1", 32'(bus.SEG), 32'h3F);
`endif

        // Further patterns checked by the model alone
        run(2);
        load(16'hFEDC, 4'b1010);
        run(64);
        load(16'h0100, 4'b0001);
        run(40);
        load(16'h3B5D, 4'b1111);
        run(64);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
